// File: rtl/uart_csr_block.sv
// uart_csr_block: register-side owner of the UART CSR interface.
// Holds the baud divisor, control and status registers, serves single-beat
// host reads/writes with a one-cycle response, and captures core events into
// sticky W1C status bits that drive a level interrupt.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   csr_req/we/addr/wdata  host request (one beat per cycle, no back-pressure)
//   csr_rdata/rvalid/err   host response, one cycle after the request
//   uart_baud_rate_csr     baud divisor to the core
//   uart_control_0_csr     control fields to the core
//   uart_status_0_csr      status image (same as a STATUS_0 read)
//   parity_error/busy/free core flags
//   irq                    level interrupt
module uart_csr_block #(
  parameter int unsigned             DATA_W   = 32,
  parameter int unsigned             ADDR_W   = 4,
  parameter int unsigned             BAUD_W   = 16,
  parameter logic [BAUD_W-1:0]       BAUD_RST = 16'd27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_req,
  input  logic              csr_we,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [DATA_W-1:0] csr_wdata,
  output logic [DATA_W-1:0] csr_rdata,
  output logic              csr_rvalid,
  output logic              csr_err,
  output logic [BAUD_W-1:0] uart_baud_rate_csr,
  output logic [7:0]        uart_control_0_csr,
  output logic [7:0]        uart_status_0_csr,
  input  logic              parity_error,
  input  logic              busy,
  input  logic              free,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(2);

  logic [BAUD_W-1:0] baud, baud_nx;
  logic [7:0]        control, control_nx;
  logic              perr_sticky, done_sticky, perr_nx, done_nx;
  logic              parity_q, busy_q, free_q;
  logic              perr_set, done_set;
  logic [1:0]        w1c;
  logic [DATA_W-1:0] rdata_nx;
  logic              err_nx, irq_nx;
  logic [7:0]        status_img;

  assign status_img = {4'b0000, free_q, busy_q, done_sticky, perr_sticky};

  always_comb begin
    baud_nx    = baud;
    control_nx = control;
    rdata_nx   = '0;
    err_nx     = 1'b0;
    w1c        = '0;
    perr_set   = parity_error & ~parity_q;
    done_set   = ~busy & busy_q;

    if (csr_req) begin
      unique case (csr_addr)
        A_BAUD: begin
          if (csr_we) begin
            // A zero divisor is rejected so the core never sees it.
            if (csr_wdata[BAUD_W-1:0] == '0) err_nx = 1'b1;
            else                             baud_nx = csr_wdata[BAUD_W-1:0];
          end else begin
            rdata_nx = DATA_W'(baud);
          end
        end
        A_CTRL: begin
          if (csr_we) control_nx = csr_wdata[7:0];
          else        rdata_nx   = DATA_W'(control);
        end
        A_STAT: begin
          if (csr_we) w1c      = csr_wdata[1:0];
          else        rdata_nx = DATA_W'(status_img);
        end
        default: err_nx = 1'b1;
      endcase
    end

    // A new event in the same cycle as its W1C wins.
    perr_nx = perr_set | (perr_sticky & ~w1c[0]);
    done_nx = done_set | (done_sticky & ~w1c[1]);
    // Built from next-state values so irq rises with the sticky bit.
    irq_nx  = (perr_nx & control_nx[6]) | (done_nx & control_nx[7]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud        <= BAUD_RST;
      control     <= '0;
      perr_sticky <= 1'b0;
      done_sticky <= 1'b0;
      parity_q    <= 1'b0;
      busy_q      <= 1'b0;
      free_q      <= 1'b0;
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      csr_err     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      baud        <= baud_nx;
      control     <= control_nx;
      perr_sticky <= perr_nx;
      done_sticky <= done_nx;
      parity_q    <= parity_error;
      busy_q      <= busy;
      free_q      <= free;
      csr_rdata   <= rdata_nx;
      csr_rvalid  <= csr_req;
      csr_err     <= err_nx;
      irq         <= irq_nx;
    end
  end

  assign uart_baud_rate_csr = baud;
  assign uart_control_0_csr = control;
  assign uart_status_0_csr  = status_img;

endmodule
